// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, row sampling, ghost rejection
// and a scan-level debounce FSM that reports accepted presses as hex codes.
module keypad_scanner #(
    parameter int unsigned SCAN_PERIOD    = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned SLOT_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NKEYS  = 16;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0]  DB_TARGET = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HELD  = 2'd2,
        S_REL   = 2'd3
    } state_t;

    logic [3:0]        row_meta;
    logic [3:0]        row_sync;
    logic [SLOT_W-1:0] slot_q;
    logic [1:0]        col_idx_q;
    logic [1:0]        col_idx_nxt;
    logic [NKEYS-1:0]  acc_q;
    logic [NKEYS-1:0]  scan_vec;
    logic [4:0]        hit_cnt;
    logic [3:0]        hit_code;
    logic              scan_key;
    logic              sample;
    logic              eos;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]        cand_q, cand_d;
    logic [3:0]        code_d;
    logic              valid_d;
    logic              down_d;

    assign sample      = (slot_q == SLOT_LAST);
    assign eos         = sample && (col_idx_q == 2'd3);
    assign col_idx_nxt = col_idx_q + 2'd1;
    assign cnt_inc     = cnt_q + CNT_W'(1);

    // Synchronizer, slot counter, column drive and per-scan accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            slot_q    <= '0;
            col_idx_q <= 2'd0;
            col_out   <= 4'b1110;
            acc_q     <= '0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
            if (sample) begin
                slot_q    <= '0;
                col_idx_q <= col_idx_nxt;
                col_out   <= ~(4'b0001 << col_idx_nxt);
                acc_q     <= eos ? '0 : scan_vec;
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
        end
    end

    // Accumulated scan including this cycle's sample; bit index is {row, col}
    always_comb begin
        scan_vec = acc_q;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                scan_vec[{2'(r), col_idx_q}] = 1'b1;
            end
        end
    end

    // Count pressed positions; a single hit yields its code, anything else is NONE
    always_comb begin
        hit_cnt  = 5'd0;
        hit_code = 4'd0;
        for (int i = 0; i < NKEYS; i++) begin
            if (scan_vec[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = 4'(i);
            end
        end
        scan_key = (hit_cnt == 5'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cand_q    <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_down  <= down_d;
        end
    end

    // Debounce FSM, advanced only at end of scan
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = key_code;
        valid_d = 1'b0;
        down_d  = key_down;
        if (eos) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_key) begin
                        cand_d  = hit_code;
                        cnt_d   = CNT_W'(1);
                        state_d = S_PRESS;
                    end
                end
                S_PRESS: begin
                    if (scan_key && (hit_code == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_TARGET) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            state_d = S_HELD;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (!(scan_key && (hit_code == key_code))) begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_REL;
                    end
                end
                S_REL: begin
                    if (scan_key && (hit_code == key_code)) begin
                        state_d = S_HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_TARGET) begin
                            down_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix emulation, a vector table,
// hand-written timing sequences and randomized scans against a scan-level model.
module tb_keypad_scanner;

    localparam int unsigned SP   = 8;
    localparam int unsigned DB   = 3;
    localparam int unsigned SCAN = 4 * SP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = 16'h0000;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    // Scan-level reference state
    logic       m_down, m_valid;
    logic [3:0] m_code, streak_key;
    int         streak_len, miss_len, m_pulses;

    typedef struct {
        logic [15:0] mask;
        logic        v;
        logic        d;
        logic [3:0]  code;
    } vec_t;
    vec_t tbl[$];

    keypad_scanner #(.SCAN_PERIOD(SP), .DEBOUNCE_SCANS(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column while that column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(negedge clk) if (rst && key_valid) pulses++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_down = 0; m_valid = 0; m_code = 0; streak_key = 0;
        streak_len = 0; miss_len = 0;
    endtask

    // One full scan of the given pressed set, judged by the debounce rules
    task automatic model_eos(input logic [15:0] mask);
        bit         is_key;
        logic [3:0] k;
        is_key = ($countones(mask) == 1);
        k = 4'd0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = 4'(i);
        m_valid = 0;
        if (m_down) begin
            if (is_key && k == m_code) miss_len = 0;
            else miss_len++;
            if (miss_len == int'(DB)) begin
                m_down = 0; miss_len = 0; streak_len = 0;
            end
        end else begin
            if (streak_len > 0) begin
                if (is_key && k == streak_key) streak_len++;
                else streak_len = 0;
            end else if (is_key) begin
                streak_key = k; streak_len = 1;
            end
            if (streak_len == int'(DB)) begin
                m_down = 1; m_valid = 1; m_code = streak_key;
                streak_len = 0; miss_len = 0; m_pulses++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic scan_and_check(input string name);
        logic [15:0] m;
        m = pressed;
        repeat (SCAN) @(posedge clk);
        #1;
        model_eos(m);
        check({name, ".valid"}, 16'(key_valid), 16'(m_valid));
        check({name, ".down"},  16'(key_down),  16'(m_down));
        check({name, ".code"},  16'(key_code),  16'(m_code));
    endtask

    initial begin
        int p0, mp0, sel;
        logic [3:0] ka, kb;
        logic [3:0] col_exp;
        m_pulses = 0;
        model_reset();

        // Vector table, one entry per scan after reset (SP=8, DB=3)
        for (int i = 0; i < 2; i++) tbl.push_back('{16'h0200, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{16'h0200, 1'b1, 1'b1, 4'h9});
        for (int i = 0; i < 3; i++) tbl.push_back('{16'h0200, 1'b0, 1'b1, 4'h9});
        for (int i = 0; i < 2; i++) tbl.push_back('{16'h0000, 1'b0, 1'b1, 4'h9});
        tbl.push_back('{16'h0000, 1'b0, 1'b0, 4'h9});
        for (int i = 0; i < 8; i++) tbl.push_back('{(i % 2 == 0) ? 16'h0200 : 16'h0000, 1'b0, 1'b0, 4'h9});
        for (int i = 0; i < 5; i++) tbl.push_back('{16'h8001, 1'b0, 1'b0, 4'h9});
        for (int i = 0; i < 2; i++) tbl.push_back('{16'h8000, 1'b0, 1'b0, 4'h9});
        tbl.push_back('{16'h8000, 1'b1, 1'b1, 4'hF});
        for (int i = 0; i < 2; i++) tbl.push_back('{16'h0000, 1'b0, 1'b1, 4'hF});
        tbl.push_back('{16'h0000, 1'b0, 1'b0, 4'hF});

        // Reset values and column stepping
        pressed = 16'h0000;
        do_reset();
        #1;
        check("rst.col", 16'(col_out), 16'h000E);
        check("rst.code", 16'(key_code), 16'h0);
        check("rst.down", 16'(key_down), 16'h0);
        for (int k = 1; k <= 4; k++) begin
            repeat (SP) @(posedge clk);
            #1;
            col_exp = ~(4'b0001 << (k % 4));
            check("col.step", 16'(col_out), 16'(col_exp));
        end

        // Table-driven scans
        pressed = tbl[0].mask;
        do_reset();
        foreach (tbl[i]) begin
            pressed = tbl[i].mask;
            repeat (SCAN) @(posedge clk);
            #1;
            check("tbl.valid", 16'(key_valid), 16'(tbl[i].v));
            check("tbl.down",  16'(key_down),  16'(tbl[i].d));
            check("tbl.code",  16'(key_code),  16'(tbl[i].code));
        end

        // Exact press latency: pulse in cycle 96 only, held for 6 scans
        pressed = 16'h0200;
        do_reset();
        p0 = pulses;
        repeat (95) @(posedge clk);
        #1 check("lat.before", 16'(key_valid), 16'h0);
        @(posedge clk);
        #1 check("lat.pulse", 16'(key_valid), 16'h1);
        check("lat.down", 16'(key_down), 16'h1);
        check("lat.code", 16'(key_code), 16'h9);
        @(posedge clk);
        #1 check("lat.after", 16'(key_valid), 16'h0);
        repeat (3 * SCAN - 2) @(posedge clk);
        #1 check("hold.down", 16'(key_down), 16'h1);
        check("hold.pulses", 16'(pulses - p0), 16'h1);

        // Release variant: one empty scan then re-press; then ghost release while held
        pressed = 16'h0200;
        do_reset();
        p0 = pulses; mp0 = m_pulses;
        repeat (3) scan_and_check("seq.press");
        pressed = 16'h0000;
        scan_and_check("seq.gap");
        pressed = 16'h0200;
        repeat (3) scan_and_check("seq.repress");
        check("seq.onepulse", 16'(pulses - p0), 16'h1);
        pressed = 16'h0201;
        repeat (3) scan_and_check("seq.ghostrel");
        check("seq.ghostdown", 16'(key_down), 16'h0);

        // Reset mid-scan while held
        pressed = 16'h0200;
        repeat (3) scan_and_check("rsth.press");
        repeat (13) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rsth.col", 16'(col_out), 16'h000E);
        check("rsth.down", 16'(key_down), 16'h0);
        check("rsth.valid", 16'(key_valid), 16'h0);
        check("rsth.code", 16'(key_code), 16'h0);

        // Randomized scans against the model
        pressed = 16'h0000;
        do_reset();
        p0 = pulses; mp0 = m_pulses;
        for (int s = 0; s < 150; s++) begin
            sel = int'($urandom_range(0, 9));
            if (sel >= 5 && sel <= 6) begin
                pressed = 16'h0000;
            end else if (sel >= 7 && sel <= 8) begin
                ka = 4'($urandom_range(0, 15));
                pressed = 16'(1) << ka;
            end else if (sel == 9) begin
                ka = 4'($urandom_range(0, 15));
                kb = ka + 4'($urandom_range(1, 15));
                pressed = (16'(1) << ka) | (16'(1) << kb);
            end
            scan_and_check("rand");
        end
        check("rand.pulses", 16'(pulses - p0), 16'(m_pulses - mp0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4×4 active-low matrix keypad and reports debounced key presses as 4-bit hex codes. It is the input-side counterpart of the multiplexed 7-segment display path. It drives one column low at a time on a fixed slot period and samples the rows near the end of each slot. A scan-level debounce FSM turns raw per-scan results into a one-cycle `key_valid` pulse and a `key_down` level. It sits beside the display driver in the miner's front-panel logic, and its `key_code` feeds control and config registers.

## Interface
- `SCAN_PERIOD`, default 1000: clock cycles per column slot. Legal range 4..65536.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full-scan results needed to accept a press or a release. Legal range 2..15.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out`  out  4  column drive, active-low; exactly one bit is low at any time.
- `key_code`  out  4  code of the accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_down`  out  1  high while the accepted key is held.

## Operation
- `row_in` passes through a 2-FF synchronizer, and all decisions use the synchronized value.
- Slot counter: 16 bits, counts 0..`SCAN_PERIOD`-1, then wraps to 0.
  - On the wrap, `col_idx` advances 0→1→2→3→0.
  - `col_out` = ~(1 << `col_idx`).
- Sample point: the cycle where the counter equals `SCAN_PERIOD`-1. The synchronized rows are captured into a per-scan accumulator for the current column.
- End-of-scan (EOS): the sample point with `col_idx`==3. At EOS the scan result is computed:
  - exactly one pressed position → KEY(code);
  - zero pressed positions → NONE;
  - two or more pressed positions → NONE (ghosting rejected).
  - The accumulator then clears for the next scan.
- The FSM updates only at EOS; counter `cnt` is 4 bits.
  - IDLE: on KEY(k), set `cand`=k, `cnt`=1, go to PRESS. On NONE, stay.
  - PRESS: on KEY(`cand`), increment `cnt`. When the new value equals `DEBOUNCE_SCANS`: `key_code`←`cand`, pulse `key_valid`, `key_down`←1, go to HELD. Any other result (NONE or a different key) goes to IDLE; no immediate restart.
  - HELD: on KEY(`key_code`), stay. Anything else sets `cnt`=1 and goes to REL.
  - REL: on KEY(`key_code`), return to HELD with no new pulse. Otherwise increment `cnt`. When it reaches `DEBOUNCE_SCANS`: `key_down`←0, go to IDLE.
- `key_code` holds its last accepted value after release.
- Auto-repeat is not supported: a held key produces exactly one `key_valid`.

## Timing
- Reset values (asynchronous on `rst` low):
  - counter = 0, `col_idx` = 0, `col_out` = 4'b1110;
  - synchronizers = 4'hF, accumulator cleared;
  - state IDLE, `cnt` = 0, `cand` = 0;
  - `key_code` = 0, `key_valid` = 0, `key_down` = 0.
- Reset mid-operation aborts any press or release in progress, with no pulse.
- After `rst` deasserts, the first scan starts at counter 0 with column 0.
- `col_out` changes in the cycle after the wrap edge. Rows therefore have `SCAN_PERIOD`-1 cycles to settle before sampling.
- A row level must be stable at `row_in` for at least 2 cycles before the sample point to be seen (synchronizer latency).
- One scan takes 4×`SCAN_PERIOD` cycles.
- Press latency:
  - `key_valid` and `key_down` rise in the cycle after the `DEBOUNCE_SCANS`-th consecutive EOS with a matching KEY;
  - `key_valid` falls in the following cycle.
- Release latency: `key_down` falls in the cycle after the `DEBOUNCE_SCANS`-th consecutive non-matching EOS.
- `key_valid` and `key_down` are registered outputs; neither changes between EOS edges.

## Test plan
- Reset: hold `rst` low mid-scan while in HELD → immediately `col_out`=4'b1110, `key_down`=0, `key_valid`=0, `key_code`=0. After release, `col_out` steps 1110→1101→1011→0111→1110 every `SCAN_PERIOD` cycles.
- Clean press (`SCAN_PERIOD`=8, `DEBOUNCE_SCANS`=3): pull row 2 low while column 1 is driven, from before scan 1, held for 6 scans → a single `key_valid` pulse with `key_code`=4'h9 in the cycle after EOS 3 (cycle 96 after the scan start); `key_down`=1 throughout; no second pulse.
- Bounce: same key present for one scan, absent for one, alternating for 8 scans → no `key_valid`; `key_down` stays 0.
- Release: after acceptance, release the key → `key_down` falls in the cycle after the 3rd empty EOS. A variant with one empty scan followed by a re-press → `key_down` stays 1 and no new pulse.
- Ghosting: row 0 col 0 and row 3 col 3 pressed together for 5 scans → no pulse. While 4'h9 is held, also pressing 4'h0 for 3 scans → `key_down` falls, as a release.
- Wrap and last slot: row 3 on column 3 → `key_code`=4'hF. Confirms that the sample on the column-3 slot and EOS coincide correctly.
